// File: rtl/rr_mux_arbiter2.sv
// Round-robin arbiter for two valid/ready sources: drives the 2:1 mux bank SEL and a one-entry output slot.
// Optional: define RR_MUX_ARB_PKT_LOCK_EN to hold each grant until the granted source's LAST beat.
module rr_mux_arbiter2 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_VALID,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             A_LAST,
  output logic             A_READY,
  input  logic             B_VALID,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             B_LAST,
  output logic             B_READY,
  output logic             SEL,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_LAST,
  input  logic             OUT_READY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               sel_q, sel_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic               slot_free_s;
  logic               stall_s;
  logic               a_acc_s;
  logic               b_acc_s;
  logic               grant_end_s;

  // prio: 0 favours A, 1 favours B when both sources request together
  function automatic state_t arb(input logic a_v, input logic b_v, input logic prio);
    state_t res;
    case ({a_v, b_v})
      2'b10:   res = GRANT_A;
      2'b01:   res = GRANT_B;
      2'b11:   res = prio ? GRANT_B : GRANT_A;
      default: res = IDLE;
    endcase
    return res;
  endfunction

  assign slot_free_s = ~out_valid_q | OUT_READY;
  assign stall_s     = out_valid_q & ~OUT_READY;
  assign A_READY     = (state_q == GRANT_A) & slot_free_s;
  assign B_READY     = (state_q == GRANT_B) & slot_free_s;
  assign a_acc_s     = A_VALID & A_READY;
  assign b_acc_s     = B_VALID & B_READY;

`ifdef RR_MUX_ARB_PKT_LOCK_EN
  assign grant_end_s = (a_acc_s & A_LAST) | (b_acc_s & B_LAST);
`else
  assign grant_end_s = a_acc_s | b_acc_s;
`endif

  // Slot load/drain and grant sequencing; a finishing grant re-arbitrates in the same cycle
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (a_acc_s) begin
      out_valid_d = 1'b1;
      out_data_d  = A_DATA;
      out_last_d  = A_LAST;
    end else if (b_acc_s) begin
      out_valid_d = 1'b1;
      out_data_d  = B_DATA;
      out_last_d  = B_LAST;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (stall_s) begin
      state_d = state_q;
    end else if (grant_end_s) begin
      prio_d  = a_acc_s ? 1'b1 : 1'b0;
      state_d = arb(A_VALID, B_VALID, prio_d);
    end else if (state_q == IDLE) begin
      state_d = arb(A_VALID, B_VALID, prio_q);
    end else begin
      state_d = state_q;
    end

    // SEL follows the granted source and keeps its last value while idle
    case (state_d)
      GRANT_A: sel_d = 1'b0;
      GRANT_B: sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  // State, priority, select and output slot registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign SEL       = sel_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_LAST  = out_last_q;

endmodule
